frv_mem_arbiter: RTL and testbench

- Two-into-one arbiter merging the FRV core's instruction channel (imem) and data channel (dmem) onto one request/response channel.
- The merged channel feeds the team's BRAM adapter, so a single-port BRAM serves both channels.
- Tracks the source of every accepted request in an in-order ID FIFO and routes each response back to the channel that issued it.

---
 rtl/frv_mem_arb_pkg.sv | 20 ++
 rtl/frv_mem_arb_idfifo.sv | 69 ++++++
 rtl/frv_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_frv_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frv_mem_arb_pkg.sv
// rtl/frv_mem_arb_pkg.sv - shared constants and helpers for the imem/dmem arbiter
//
// Purpose: source IDs stored in the ID FIFO, request bus field widths and
//          a pointer-width helper used by the FIFO.
// Ports:   none (package)
package frv_mem_arb_pkg;

  localparam logic ARB_SRC_IMEM = 1'b0;
  localparam logic ARB_SRC_DMEM = 1'b1;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // A DEPTH of 1 still needs a 1-bit pointer to be a legal vector.
  function automatic int arb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/frv_mem_arb_idfifo.sv
// rtl/frv_mem_arb_idfifo.sv - in-order source-ID FIFO for outstanding requests
//
// Purpose: remembers which channel issued each accepted request so responses
//          can be routed back in order.
// Ports:   g_clk, g_resetn    clock, synchronous active-low reset
//          push, push_src     write push_src at the write pointer
//          pop                retire the head entry
//          full, empty, head  status and current head source ID
module frv_mem_arb_idfifo
  import frv_mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic g_clk,
  input  logic g_resetn,
  input  logic push,
  input  logic push_src,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = arb_ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Entry storage needs no reset: count gates every use of head.
  always_ff @(posedge g_clk) begin
    if (push) begin
      mem[wr_ptr] <= push_src;
    end
  end

  // When full with a simultaneous pop, wr_ptr == rd_ptr: the head is read
  // combinationally this cycle and the freed slot is overwritten at the edge.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frv_mem_arbiter.sv
// rtl/frv_mem_arbiter.sv - two-into-one imem/dmem arbiter onto one memory channel
//
// Purpose: merges the instruction and data request channels onto a single
//          request/response channel; responses return in order and are
//          steered back to the issuing channel via an ID FIFO.
//          Optional macro FRV_MEM_ARB_RR_EN: round-robin tie break
//          (default build: dmem always wins a tie).
// Ports:   g_clk, g_resetn                  clock, synchronous active-low reset
//          imem_*/dmem_*                    upstream channels (req/gnt, wen,
//                                           strb, wdata, addr, recv/ack,
//                                           error, rdata)
//          m_*                              merged downstream channel
module frv_mem_arbiter
  import frv_mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              g_clk,
  input  logic              g_resetn,

  input  logic              imem_req,
  output logic              imem_gnt,
  input  logic              imem_wen,
  input  logic [STRB_W-1:0] imem_strb,
  input  logic [DATA_W-1:0] imem_wdata,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic              imem_recv,
  input  logic              imem_ack,
  output logic              imem_error,
  output logic [DATA_W-1:0] imem_rdata,

  input  logic              dmem_req,
  output logic              dmem_gnt,
  input  logic              dmem_wen,
  input  logic [STRB_W-1:0] dmem_strb,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_recv,
  input  logic              dmem_ack,
  output logic              dmem_error,
  output logic [DATA_W-1:0] dmem_rdata,

  output logic              m_req,
  input  logic              m_gnt,
  output logic              m_wen,
  output logic [STRB_W-1:0] m_strb,
  output logic [DATA_W-1:0] m_wdata,
  output logic [ADDR_W-1:0] m_addr,
  input  logic              m_recv,
  output logic              m_ack,
  input  logic              m_error,
  input  logic [DATA_W-1:0] m_rdata
);

  logic sel;
  logic dmem_pri;
  logic can_push;
  logic push;
  logic pop;
  logic fifo_full;
  logic fifo_empty;
  logic head;
  logic head_valid;

`ifdef FRV_MEM_ARB_RR_EN
  // last_sel holds the source of the most recent accepted request; a tie
  // goes to the other channel.
  logic last_sel;

  assign dmem_pri = (last_sel == ARB_SRC_IMEM);

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      last_sel <= ARB_SRC_IMEM;
    end else if (push) begin
      last_sel <= sel;
    end
  end
`else
  assign dmem_pri = 1'b1;
`endif

  assign sel = (dmem_req && (!imem_req || dmem_pri)) ? ARB_SRC_DMEM : ARB_SRC_IMEM;

  // Request path. A pop in the same cycle frees a slot, so a full FIFO can
  // still accept.
  assign can_push = !fifo_full || pop;
  assign m_req    = (imem_req || dmem_req) && can_push;
  assign push     = m_req && m_gnt;

  assign imem_gnt = m_gnt && can_push && (sel == ARB_SRC_IMEM) && imem_req;
  assign dmem_gnt = m_gnt && can_push && (sel == ARB_SRC_DMEM) && dmem_req;

  always_comb begin
    m_wen   = imem_wen;
    m_strb  = imem_strb;
    m_wdata = imem_wdata;
    m_addr  = imem_addr;
    if (sel == ARB_SRC_DMEM) begin
      m_wen   = dmem_wen;
      m_strb  = dmem_strb;
      m_wdata = dmem_wdata;
      m_addr  = dmem_addr;
    end
  end

  // Response path. A response arriving with nothing outstanding is dropped:
  // no recv and no ack are produced.
  assign head_valid = !fifo_empty;
  assign imem_recv  = m_recv && head_valid && (head == ARB_SRC_IMEM);
  assign dmem_recv  = m_recv && head_valid && (head == ARB_SRC_DMEM);
  assign m_ack      = head_valid && ((head == ARB_SRC_DMEM) ? dmem_ack : imem_ack);
  assign pop        = m_recv && m_ack;

  assign imem_rdata = imem_recv ? m_rdata : '0;
  assign imem_error = imem_recv && m_error;
  assign dmem_rdata = dmem_recv ? m_rdata : '0;
  assign dmem_error = dmem_recv && m_error;

  frv_mem_arb_idfifo #(
    .DEPTH (DEPTH)
  ) u_idfifo (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .push     (push),
    .push_src (sel),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// tb/tb_frv_mem_arbiter.sv - scoreboard bench for the imem/dmem arbiter
module tb_frv_mem_arbiter;

  typedef struct packed {
    logic        src;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        imem_req, imem_gnt, imem_wen, imem_recv, imem_ack, imem_error;
  logic [3:0]  imem_strb;
  logic [31:0] imem_wdata, imem_addr, imem_rdata;
  logic        dmem_req, dmem_gnt, dmem_wen, dmem_recv, dmem_ack, dmem_error;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_wdata, dmem_addr, dmem_rdata;
  logic        m_req, m_gnt, m_wen, m_recv, m_ack, m_error;
  logic [3:0]  m_strb;
  logic [31:0] m_wdata, m_addr, m_rdata;

  exp_t sb[$];
  exp_t e;
  int   vectors    = 0;
  int   miscompares = 0;
  logic first_src;

  always #5 g_clk = ~g_clk;

  frv_mem_arbiter #(.DEPTH(2)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_wen(imem_wen), .imem_strb(imem_strb),
    .imem_wdata(imem_wdata), .imem_addr(imem_addr), .imem_recv(imem_recv), .imem_ack(imem_ack),
    .imem_error(imem_error), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_addr(dmem_addr), .dmem_recv(dmem_recv), .dmem_ack(dmem_ack),
    .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
    .m_req(m_req), .m_gnt(m_gnt), .m_wen(m_wen), .m_strb(m_strb), .m_wdata(m_wdata),
    .m_addr(m_addr), .m_recv(m_recv), .m_ack(m_ack), .m_error(m_error), .m_rdata(m_rdata)
  );

  task automatic next_cycle;
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle;
    imem_req = 0; imem_wen = 0; imem_strb = 0; imem_wdata = 0; imem_addr = 0; imem_ack = 0;
    dmem_req = 0; dmem_wen = 0; dmem_strb = 0; dmem_wdata = 0; dmem_addr = 0; dmem_ack = 0;
    m_gnt = 0; m_recv = 0; m_error = 0; m_rdata = 0;
  endtask

  task automatic test_reset;
    g_resetn = 0;
    idle();
    next_cycle();
    next_cycle();
    #4;
    vectors++;
    if ({imem_gnt, dmem_gnt, m_req, m_ack, imem_recv, dmem_recv, imem_error, dmem_error} !== 8'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {imem_gnt, dmem_gnt, m_req, m_ack, imem_recv, dmem_recv, imem_error, dmem_error});
    end
    vectors++;
    if ({m_addr, m_wdata, imem_rdata, dmem_rdata} !== 128'b0) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 0", {m_addr, m_wdata, imem_rdata, dmem_rdata});
    end
    vectors++;
    if (dut.u_idfifo.count !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_count: got %0d expected 0", dut.u_idfifo.count);
    end
    g_resetn = 1;
    next_cycle();
  endtask

  task automatic test_single_imem;
    idle();
    imem_req = 1; imem_addr = 32'h0000_0010; m_gnt = 1;
    #4;
    vectors++;
    if ({imem_gnt, dmem_gnt, m_req} !== 3'b101 || m_addr !== 32'h10 || m_wen !== 1'b0) begin
      miscompares++;
      $display("FAIL single_req: gnt/req %b addr %h wen %b expected 101 00000010 0",
               {imem_gnt, dmem_gnt, m_req}, m_addr, m_wen);
    end
    sb.push_back(exp_t'{src: 1'b0, err: 1'b0, data: 32'hDEAD_BEEF});
    next_cycle();
    idle();
    m_recv = 1; m_rdata = 32'hDEAD_BEEF; imem_ack = 1;
    #4;
    vectors++;
    e = sb.pop_front();
    if ({imem_recv, dmem_recv} !== (e.src ? 2'b01 : 2'b10) ||
        (e.src ? dmem_rdata : imem_rdata) !== e.data || m_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL single_resp: recv %b rdata %h ack %b expected src %b data %h ack 1",
               {imem_recv, dmem_recv}, imem_rdata, m_ack, e.src, e.data);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_tie;
`ifdef FRV_MEM_ARB_RR_EN
    first_src = 1'b0;
`else
    first_src = 1'b1;
`endif
    // Lone dmem request: leaves the round-robin state pointing at dmem.
    idle();
    dmem_req = 1; dmem_addr = 32'h300; m_gnt = 1;
    #4;
    vectors++;
    if ({imem_gnt, dmem_gnt} !== 2'b01) begin
      miscompares++;
      $display("FAIL tie_pre_gnt: got %b expected 01", {imem_gnt, dmem_gnt});
    end
    sb.push_back(exp_t'{src: 1'b1, err: 1'b0, data: 32'h0000_0300});
    next_cycle();
    idle();
    m_recv = 1; m_rdata = 32'h0000_0300; dmem_ack = 1; imem_ack = 1;
    #4;
    vectors++;
    e = sb.pop_front();
    if ({imem_recv, dmem_recv} !== (e.src ? 2'b01 : 2'b10) ||
        (e.src ? dmem_rdata : imem_rdata) !== e.data) begin
      miscompares++;
      $display("FAIL tie_pre_resp: recv %b data %h expected src %b data %h",
               {imem_recv, dmem_recv}, e.src ? dmem_rdata : imem_rdata, e.src, e.data);
    end
    next_cycle();
    // Both channels request together.
    idle();
    imem_req = 1; imem_addr = 32'h100;
    dmem_req = 1; dmem_addr = 32'h200; dmem_wen = 1; dmem_strb = 4'hF; dmem_wdata = 32'h55;
    m_gnt = 1;
    #4;
    vectors++;
    if ({imem_gnt, dmem_gnt} !== (first_src ? 2'b01 : 2'b10) ||
        m_addr !== (first_src ? 32'h200 : 32'h100)) begin
      miscompares++;
      $display("FAIL tie_first: gnt %b addr %h expected winner %b", {imem_gnt, dmem_gnt}, m_addr, first_src);
    end
    sb.push_back(exp_t'{src: first_src, err: 1'b0, data: 32'h0000_00A0});
    next_cycle();
    imem_req = first_src;
    dmem_req = !first_src;
    #4;
    vectors++;
    if ({imem_gnt, dmem_gnt} !== (first_src ? 2'b10 : 2'b01)) begin
      miscompares++;
      $display("FAIL tie_second: gnt %b expected loser %b", {imem_gnt, dmem_gnt}, !first_src);
    end
    sb.push_back(exp_t'{src: !first_src, err: 1'b0, data: 32'h0000_00B0});
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      idle();
      m_recv = 1; m_rdata = (i == 0) ? 32'hA0 : 32'hB0; imem_ack = 1; dmem_ack = 1;
      #4;
      vectors++;
      e = sb.pop_front();
      if ({imem_recv, dmem_recv} !== (e.src ? 2'b01 : 2'b10) ||
          (e.src ? dmem_rdata : imem_rdata) !== e.data || m_ack !== 1'b1) begin
        miscompares++;
        $display("FAIL tie_resp%0d: recv %b ack %b expected src %b data %h",
                 i, {imem_recv, dmem_recv}, m_ack, e.src, e.data);
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_back_to_back;
    idle();
    imem_req = 1; imem_addr = 32'h10; m_gnt = 1;
    sb.push_back(exp_t'{src: 1'b0, err: 1'b0, data: 32'h1111_1111});
    next_cycle();
    imem_req = 0; dmem_req = 1; dmem_addr = 32'h20;
    sb.push_back(exp_t'{src: 1'b1, err: 1'b0, data: 32'h2222_2222});
    next_cycle();
    // Full: no further request may pass while nothing is retired.
    dmem_req = 0; imem_req = 1; imem_addr = 32'h30;
    #4;
    vectors++;
    if (dut.u_idfifo.count !== 2'd2 || {m_req, imem_gnt, dmem_gnt} !== 3'b000) begin
      miscompares++;
      $display("FAIL full_block: count %0d req/gnt %b expected 2 000",
               dut.u_idfifo.count, {m_req, imem_gnt, dmem_gnt});
    end
    next_cycle();
    // Full with a pop: the freed slot accepts the new request.
    m_recv = 1; m_rdata = 32'h1111_1111; imem_ack = 1;
    #4;
    vectors++;
    if ({m_req, imem_gnt, m_ack} !== 3'b111) begin
      miscompares++;
      $display("FAIL full_pop_push: req/gnt/ack %b expected 111", {m_req, imem_gnt, m_ack});
    end
    vectors++;
    e = sb.pop_front();
    if ({imem_recv, dmem_recv} !== (e.src ? 2'b01 : 2'b10) || (e.src ? dmem_rdata : imem_rdata) !== e.data) begin
      miscompares++;
      $display("FAIL b2b_resp0: recv %b expected src %b data %h", {imem_recv, dmem_recv}, e.src, e.data);
    end
    sb.push_back(exp_t'{src: 1'b0, err: 1'b0, data: 32'h3333_3333});
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      idle();
      m_recv = 1; m_rdata = (i == 0) ? 32'h2222_2222 : 32'h3333_3333; imem_ack = 1; dmem_ack = 1;
      #4;
      vectors++;
      e = sb.pop_front();
      if ({imem_recv, dmem_recv} !== (e.src ? 2'b01 : 2'b10) ||
          (e.src ? dmem_rdata : imem_rdata) !== e.data) begin
        miscompares++;
        $display("FAIL b2b_resp%0d: recv %b expected src %b data %h", i + 1, {imem_recv, dmem_recv}, e.src, e.data);
      end
      next_cycle();
    end
    idle();
    #4;
    vectors++;
    if (dut.u_idfifo.count !== 2'd0) begin
      miscompares++;
      $display("FAIL b2b_drain: count %0d expected 0", dut.u_idfifo.count);
    end
    next_cycle();
  endtask

  task automatic test_ack_stall;
    idle();
    dmem_req = 1; dmem_addr = 32'h44; m_gnt = 1;
    sb.push_back(exp_t'{src: 1'b1, err: 1'b1, data: 32'h00C0_FFEE});
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      idle();
      m_recv = 1; m_rdata = 32'h00C0_FFEE; m_error = 1; dmem_ack = 0; imem_ack = 1;
      #4;
      vectors++;
      if ({imem_recv, dmem_recv, m_ack, imem_error, dmem_error} !== 5'b01001 || dut.u_idfifo.count !== 2'd1) begin
        miscompares++;
        $display("FAIL stall%0d: recv/ack/err %b count %0d expected 01001 1",
                 i, {imem_recv, dmem_recv, m_ack, imem_error, dmem_error}, dut.u_idfifo.count);
      end
      next_cycle();
    end
    dmem_ack = 1;
    #4;
    vectors++;
    e = sb.pop_front();
    if ({imem_recv, dmem_recv} !== (e.src ? 2'b01 : 2'b10) || m_ack !== 1'b1 ||
        (e.src ? dmem_rdata : imem_rdata) !== e.data || (e.src ? dmem_error : imem_error) !== e.err) begin
      miscompares++;
      $display("FAIL stall_release: recv %b ack %b data %h expected src %b data %h err %b",
               {imem_recv, dmem_recv}, m_ack, dmem_rdata, e.src, e.data, e.err);
    end
    next_cycle();
    idle();
    #4;
    vectors++;
    if (dut.u_idfifo.count !== 2'd0) begin
      miscompares++;
      $display("FAIL stall_pop: count %0d expected 0", dut.u_idfifo.count);
    end
    next_cycle();
  endtask

  task automatic test_spurious_recv;
    idle();
    m_recv = 1; m_rdata = 32'h1234_5678; m_error = 1; imem_ack = 1; dmem_ack = 1;
    #4;
    vectors++;
    if ({imem_recv, dmem_recv, m_ack, imem_error, dmem_error} !== 5'b0 || {imem_rdata, dmem_rdata} !== 64'b0) begin
      miscompares++;
      $display("FAIL spurious: recv/ack/err %b rdata %h/%h expected 0",
               {imem_recv, dmem_recv, m_ack, imem_error, dmem_error}, imem_rdata, dmem_rdata);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_reset_mid;
    idle();
    imem_req = 1; imem_addr = 32'h50; m_gnt = 1;
    next_cycle();
    imem_req = 0; dmem_req = 1; dmem_addr = 32'h60;
    next_cycle();
    idle();
    #4;
    vectors++;
    if (dut.u_idfifo.count !== 2'd2) begin
      miscompares++;
      $display("FAIL midrst_pre: count %0d expected 2", dut.u_idfifo.count);
    end
    next_cycle();
    g_resetn = 0;
    next_cycle();
    g_resetn = 1;
    m_recv = 1; m_rdata = 32'hBAD0_BAD0; imem_ack = 1; dmem_ack = 1;
    #4;
    vectors++;
    if (dut.u_idfifo.count !== 2'd0 || {imem_recv, dmem_recv, m_ack} !== 3'b000) begin
      miscompares++;
      $display("FAIL midrst_post: count %0d recv/ack %b expected 0 000",
               dut.u_idfifo.count, {imem_recv, dmem_recv, m_ack});
    end
    next_cycle();
    idle();
    imem_req = 1; imem_addr = 32'h70; m_gnt = 1;
    #4;
    vectors++;
    if (imem_gnt !== 1'b1 || m_addr !== 32'h70) begin
      miscompares++;
      $display("FAIL midrst_req: gnt %b addr %h expected 1 00000070", imem_gnt, m_addr);
    end
    sb.push_back(exp_t'{src: 1'b0, err: 1'b0, data: 32'h7777_0000});
    next_cycle();
    idle();
    m_recv = 1; m_rdata = 32'h7777_0000; imem_ack = 1;
    #4;
    vectors++;
    e = sb.pop_front();
    if ({imem_recv, dmem_recv} !== (e.src ? 2'b01 : 2'b10) || (e.src ? dmem_rdata : imem_rdata) !== e.data) begin
      miscompares++;
      $display("FAIL midrst_resp: recv %b rdata %h expected src %b data %h",
               {imem_recv, dmem_recv}, imem_rdata, e.src, e.data);
    end
    next_cycle();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_imem();
    test_tie();
    test_back_to_back();
    test_ack_stall();
    test_spurious_recv();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: %0d entries remaining expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
